unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-ported instruction/data RAM between two requesters: the fetch stage (IF, read-only, word) and the memory stage (MEM, read/write, byte/half/word). It grants one access at a time, sequences fixed-latency RAM accesses, and returns read data with a completion pulse. It produces per-requester stall signals that the pipeline folds into its load-enable/NOP hazard logic. It sits between the IF/MEM stages and the RAM model in the CPU pipeline top.

Parameters:
ADDR_W, 8, RAM byte-address width
DATA_W, 32, data width
LAT, 2, RAM access latency in cycles (legal range 1..15); LAT=1 means a combinational-read RAM

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-low reset
IF_REQ  in  1  fetch request; held with IF_ADDR stable until IF_VALID or IF_FLUSH
IF_ADDR  in  ADDR_W  fetch address
IF_FLUSH  in  1  cancels any pending or in-flight fetch (branch taken)
IF_GNT  out  1  one-cycle pulse when the fetch is issued to the RAM
IF_RDATA  out  DATA_W  fetched word; valid when IF_VALID=1
IF_VALID  out  1  one-cycle completion pulse
IF_STALL  out  1  high when IF_REQ=1 and IF_VALID=0 and IF_FLUSH=0
MEM_REQ  in  1  data request; held stable with its qualifiers until MEM_VALID
MEM_WE  in  1  1 = write, 0 = read
MEM_SIZE  in  2  00 = byte, 01 = half, 10 = word
MEM_ADDR  in  ADDR_W  data address
MEM_WDATA  in  DATA_W  write data
MEM_RDATA  out  DATA_W  read data; valid when MEM_VALID=1
MEM_VALID  out  1  one-cycle completion pulse; also pulses for writes
MEM_STALL  out  1  high when MEM_REQ=1 and MEM_VALID=0
RAM_EN  out  1  one-cycle access strobe
RAM_WE  out  1  write strobe; qualified by RAM_EN
RAM_SIZE  out  2  access size; 10 for all fetches
RAM_ADDR  out  ADDR_W  access address
RAM_WDATA  out  DATA_W  write data
RAM_RDATA  in  DATA_W  valid during cycle t+LAT-1 for a strobe in cycle t

Behaviour:
- FSM states:
  - IDLE.
  - BUSY_IF and BUSY_MEM: a LAT-cycle access is in flight.
- Latency counter (CNT): 4 bits.
- Arbitration and issue:
  - Arbitration is combinational in IDLE only.
  - On a grant in cycle t: GNT, RAM_EN and the RAM_* fields are driven in cycle t.
  - At the end of cycle t: the FSM enters BUSY_x and CNT loads LAT-1.
- LAT=1: the FSM goes to a one-cycle COMPLETE path. Completion is still registered.
- Completion timing:
  - RAM_RDATA is captured at the edge ending cycle t+LAT-1.
  - x_VALID and x_RDATA are presented in cycle t+LAT.
  - The FSM is IDLE in cycle t+LAT.
  - Throughput is one access per LAT cycles.
- In the VALID cycle, the completing requester's REQ is masked from arbitration. The other requester may be granted in that same cycle.
- Priority when both request in IDLE:
  - The requester not served last wins (LAST bit).
  - LAST resets to IF, so MEM wins the first tie.
  - A lone requester is always granted.
- RAM_* outputs are 0 whenever RAM_EN=0. x_RDATA holds its last value. VALID/GNT are single-cycle pulses.
- IF_FLUSH:
  - Fetch in flight: a discard flag is set. IF_VALID is suppressed at completion. The FSM still waits out LAT. IF_RDATA is not updated.
  - IF_REQ pending but not granted: IF_REQ is ignored that cycle.
  - IF_FLUSH in the same cycle as an IF grant: the grant proceeds and is discarded.
  - IF_FLUSH has no effect on MEM accesses.
- Reset (RST=0 at an edge):
  - FSM=IDLE, CNT=0, LAST=IF, discard=0.
  - IF_RDATA and MEM_RDATA are 0.
  - All GNT/VALID/RAM_* outputs are 0 in the following cycle.
  - An in-flight access is abandoned and its completion is never signalled. A write already strobed is not undone.
  - STALL outputs remain combinational from REQ during reset.
- A requester dropping REQ mid-flight: the access still completes and VALID still pulses.

Decomposition:
- Shared package cpu_pkg:
  - arb_state_t (IDLE, BUSY_IF, BUSY_MEM)
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD
  - owner constants OWN_IF/OWN_MEM
- One natural sub-module, access_timer: loadable down-counter with a done flag. The top keeps the FSM, LAST bit, discard flag and data capture.

Test Plan:
1. Reset: RST=0 for 2 cycles with IF_REQ=MEM_REQ=1 -> RAM_EN, GNTs and VALIDs all 0, RDATA=0; MEM is granted in the first cycle after RST=1.
2. Lone fetch, LAT=2: IF_ADDR=0x04, RAM returns 0xDEADBEEF -> IF_GNT and RAM_EN with RAM_ADDR=0x04, RAM_SIZE=10 in cycle t; IF_STALL high in t and t+1; IF_VALID=1 with IF_RDATA=0xDEADBEEF in t+2.
3. Tie after reset: IF 0x08 and MEM word read 0x40 in the same cycle -> MEM granted at t, MEM_VALID at t+2; IF granted at t+2, IF_VALID at t+4.
4. Fairness: MEM issues back-to-back byte writes 0x10, 0x11, 0x12 with IF_REQ held -> grant order MEM, IF, MEM, IF, MEM; RAM_WE=1 only on MEM strobes; MEM_VALID pulses for each write.
5. Flush: IF_FLUSH=1 in cycle t+1 of a fetch to 0x0C -> no IF_VALID, IF_RDATA unchanged; new IF_REQ 0x20 granted at t+2.
6. Reset mid-access: RST=0 in cycle t+1 of a MEM read -> MEM_VALID never pulses; FSM IDLE; a new MEM_REQ is granted in the first cycle after release.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data RAM arbiter.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and RAM-side signals of the arbiter; slave = arbiter side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              IF_REQ;
  logic [ADDR_W-1:0] IF_ADDR;
  logic              IF_FLUSH;
  logic              IF_GNT;
  logic [DATA_W-1:0] IF_RDATA;
  logic              IF_VALID;
  logic              IF_STALL;

  logic              MEM_REQ;
  logic              MEM_WE;
  logic [1:0]        MEM_SIZE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_VALID;
  logic              MEM_STALL;

  logic              RAM_EN;
  logic              RAM_WE;
  logic [1:0]        RAM_SIZE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;

  modport slave (
    input  IF_REQ, IF_ADDR, IF_FLUSH,
    output IF_GNT, IF_RDATA, IF_VALID, IF_STALL,
    input  MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_VALID, MEM_STALL,
    output RAM_EN, RAM_WE, RAM_SIZE, RAM_ADDR, RAM_WDATA,
    input  RAM_RDATA
  );

  modport master (
    output IF_REQ, IF_ADDR, IF_FLUSH,
    input  IF_GNT, IF_RDATA, IF_VALID, IF_STALL,
    output MEM_REQ, MEM_WE, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_VALID, MEM_STALL,
    input  RAM_EN, RAM_WE, RAM_SIZE, RAM_ADDR, RAM_WDATA,
    output RAM_RDATA
  );
endinterface

// File: rtl/unified_mem_arbiter_access_timer.sv
// Loadable down-counter; done marks the last cycle of an in-flight access.
module access_timer #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter between fetch (IF) and memory (MEM) stages with
// alternating tie priority, fixed-latency sequencing and registered completion.
module unified_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input logic                   CLK,
  input logic                   RST,
  unified_mem_arbiter_if.slave  bus
);
  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic              discard_q, discard_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              if_req_m, mem_req_m;
  logic              gnt_if, gnt_mem;
  logic              tmr_load, tmr_done;
  logic [ADDR_W-1:0] ram_addr;

  access_timer #(.CNT_W(4)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (4'(LAT - 1)),
    .done     (tmr_done)
  );

  // A requester completing this cycle is excluded so the other side can issue.
  assign if_req_m  = bus.IF_REQ  & ~if_valid_q;
  assign mem_req_m = bus.MEM_REQ & ~mem_valid_q;

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (RST && state_q == IDLE) begin
      if (if_req_m && mem_req_m) begin
        if (last_q == OWN_IF) gnt_mem = 1'b1;
        else                  gnt_if  = 1'b1;
      end else if (if_req_m) begin
        gnt_if = 1'b1;
      end else if (mem_req_m) begin
        gnt_mem = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    discard_d   = discard_q;
    mem_wr_d    = mem_wr_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    tmr_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_if || gnt_mem) begin
          last_d   = gnt_mem ? OWN_MEM : OWN_IF;
          mem_wr_d = gnt_mem & bus.MEM_WE;
          if (LAT == 1) begin
            // Combinational-read RAM: capture at the end of the grant cycle.
            if (gnt_if) begin
              if (!bus.IF_FLUSH) begin
                if_valid_d = 1'b1;
                if_rdata_d = bus.RAM_RDATA;
              end
            end else begin
              mem_valid_d = 1'b1;
              if (!bus.MEM_WE) mem_rdata_d = bus.RAM_RDATA;
            end
          end else begin
            state_d   = gnt_if ? BUSY_IF : BUSY_MEM;
            tmr_load  = 1'b1;
            discard_d = gnt_if & bus.IF_FLUSH;
          end
        end
      end
      BUSY_IF: begin
        if (bus.IF_FLUSH) discard_d = 1'b1;
        if (tmr_done) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!(discard_q || bus.IF_FLUSH)) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.RAM_RDATA;
          end
        end
      end
      BUSY_MEM: begin
        if (tmr_done) begin
          state_d     = IDLE;
          mem_valid_d = 1'b1;
          if (!mem_wr_q) mem_rdata_d = bus.RAM_RDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      last_q      <= OWN_IF;
      discard_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      discard_q   <= discard_d;
      mem_wr_q    <= mem_wr_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    ram_addr = '0;
    if (gnt_if)       ram_addr = bus.IF_ADDR;
    else if (gnt_mem) ram_addr = bus.MEM_ADDR;
  end

  assign bus.RAM_EN    = gnt_if | gnt_mem;
  assign bus.RAM_WE    = gnt_mem & bus.MEM_WE;
  assign bus.RAM_SIZE  = gnt_if ? SZ_WORD : (gnt_mem ? bus.MEM_SIZE : 2'b00);
  assign bus.RAM_ADDR  = ram_addr;
  assign bus.RAM_WDATA = gnt_mem ? bus.MEM_WDATA : '0;

  assign bus.IF_GNT    = gnt_if;
  assign bus.IF_VALID  = if_valid_q;
  assign bus.IF_RDATA  = if_rdata_q;
  assign bus.IF_STALL  = bus.IF_REQ & ~if_valid_q & ~bus.IF_FLUSH;
  assign bus.MEM_VALID = mem_valid_q;
  assign bus.MEM_RDATA = mem_rdata_q;
  assign bus.MEM_STALL = bus.MEM_REQ & ~mem_valid_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (LAT=2) with a 2-cycle word RAM model.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .LAT(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // RAM: read data appears the cycle after the strobe (LAT=2).
  logic [31:0] ram [0:63];
  logic [31:0] ram_rd;
  assign bus.RAM_RDATA = ram_rd;

  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    if (!rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[1]  <= 32'hDEADBEEF;
      ram[2]  <= 32'hCAFEF00D;
      ram[3]  <= 32'h0BADF00D;
      ram[8]  <= 32'h12345678;
      ram[16] <= 32'h11223344;
      ram_rd  <= 32'h0;
    end else if (bus.RAM_EN) begin
      w = ram[bus.RAM_ADDR[7:2]];
      if (bus.RAM_WE) begin
        case (bus.RAM_SIZE)
          2'b00:   w[8*bus.RAM_ADDR[1:0] +: 8] = bus.RAM_WDATA[7:0];
          2'b01:   w[16*bus.RAM_ADDR[1] +: 16] = bus.RAM_WDATA[15:0];
          default: w = bus.RAM_WDATA;
        endcase
        ram[bus.RAM_ADDR[7:2]] <= w;
      end
      ram_rd <= ram[bus.RAM_ADDR[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.IF_REQ    = 1'b1;
    bus.IF_ADDR   = 8'h08;
    bus.IF_FLUSH  = 1'b0;
    bus.MEM_REQ   = 1'b1;
    bus.MEM_WE    = 1'b0;
    bus.MEM_SIZE  = 2'b10;
    bus.MEM_ADDR  = 8'h40;
    bus.MEM_WDATA = 32'h0;

    // Reset with both requests high, then the first tie goes to MEM.
    step(); #1;
    chk("rst_ram_en",   32'(bus.RAM_EN),    0);
    chk("rst_if_gnt",   32'(bus.IF_GNT),    0);
    chk("rst_if_vld",   32'(bus.IF_VALID),  0);
    chk("rst_mem_vld",  32'(bus.MEM_VALID), 0);
    chk("rst_if_rdata", bus.IF_RDATA,       0);
    chk("rst_mem_rdata",bus.MEM_RDATA,      0);
    chk("rst_if_stall", 32'(bus.IF_STALL),  1);
    step(); rst = 1'b1; #1;
    chk("tie_mem_en",   32'(bus.RAM_EN),    1);
    chk("tie_mem_gnt",  32'(bus.IF_GNT),    0);
    chk("tie_mem_addr", 32'(bus.RAM_ADDR),  32'h40);
    chk("tie_mem_size", 32'(bus.RAM_SIZE),  2);
    step(); #1;
    chk("tie_t1_en",    32'(bus.RAM_EN),    0);
    chk("tie_t1_addr",  32'(bus.RAM_ADDR),  0);
    chk("tie_t1_mstl",  32'(bus.MEM_STALL), 1);
    step(); #1;
    chk("tie_mem_vld",  32'(bus.MEM_VALID), 1);
    chk("tie_mem_rd",   bus.MEM_RDATA,      32'h11223344);
    chk("tie_mem_stl",  32'(bus.MEM_STALL), 0);
    chk("tie_if_gnt",   32'(bus.IF_GNT),    1);
    chk("tie_if_addr",  32'(bus.RAM_ADDR),  32'h08);
    bus.MEM_REQ = 1'b0;
    step(); #1;
    chk("tie_if_vld0",  32'(bus.IF_VALID),  0);
    step(); #1;
    chk("tie_if_vld",   32'(bus.IF_VALID),  1);
    chk("tie_if_rd",    bus.IF_RDATA,       32'hCAFEF00D);
    bus.IF_REQ = 1'b0;

    // Lone fetch of 0x04.
    step(); bus.IF_REQ = 1'b1; bus.IF_ADDR = 8'h04; #1;
    chk("f_gnt",   32'(bus.IF_GNT),   1);
    chk("f_en",    32'(bus.RAM_EN),   1);
    chk("f_addr",  32'(bus.RAM_ADDR), 32'h04);
    chk("f_size",  32'(bus.RAM_SIZE), 2);
    chk("f_stl0",  32'(bus.IF_STALL), 1);
    step(); #1;
    chk("f_stl1",  32'(bus.IF_STALL), 1);
    chk("f_vld1",  32'(bus.IF_VALID), 0);
    step(); #1;
    chk("f_vld",   32'(bus.IF_VALID), 1);
    chk("f_rd",    bus.IF_RDATA,      32'hDEADBEEF);
    chk("f_stl2",  32'(bus.IF_STALL), 0);
    bus.IF_REQ = 1'b0;

    // Fairness: byte writes alternate with held fetches.
    step();
    bus.IF_REQ = 1'b1; bus.IF_ADDR = 8'h08;
    bus.MEM_REQ = 1'b1; bus.MEM_WE = 1'b1; bus.MEM_SIZE = 2'b00;
    bus.MEM_ADDR = 8'h10; bus.MEM_WDATA = 32'h000000AA; #1;
    chk("w0_ifgnt", 32'(bus.IF_GNT),    0);
    chk("w0_we",    32'(bus.RAM_WE),    1);
    chk("w0_addr",  32'(bus.RAM_ADDR),  32'h10);
    chk("w0_size",  32'(bus.RAM_SIZE),  0);
    chk("w0_wdata", bus.RAM_WDATA,      32'hAA);
    step(); step(); #1;
    chk("w0_vld",   32'(bus.MEM_VALID), 1);
    chk("i1_gnt",   32'(bus.IF_GNT),    1);
    chk("i1_we",    32'(bus.RAM_WE),    0);
    bus.MEM_ADDR = 8'h11; bus.MEM_WDATA = 32'h000000BB;
    step(); step(); #1;
    chk("i1_vld",   32'(bus.IF_VALID),  1);
    chk("w1_ifgnt", 32'(bus.IF_GNT),    0);
    chk("w1_we",    32'(bus.RAM_WE),    1);
    chk("w1_addr",  32'(bus.RAM_ADDR),  32'h11);
    step(); step(); #1;
    chk("w1_vld",   32'(bus.MEM_VALID), 1);
    chk("i2_gnt",   32'(bus.IF_GNT),    1);
    bus.MEM_ADDR = 8'h12; bus.MEM_WDATA = 32'h000000CC;
    step(); step(); #1;
    chk("i2_vld",   32'(bus.IF_VALID),  1);
    chk("w2_we",    32'(bus.RAM_WE),    1);
    chk("w2_addr",  32'(bus.RAM_ADDR),  32'h12);
    bus.IF_REQ = 1'b0;
    step(); step(); #1;
    chk("w2_vld",   32'(bus.MEM_VALID), 1);
    chk("w2_noen",  32'(bus.RAM_EN),    0);
    bus.MEM_REQ = 1'b0;

    // Read back the byte-written word.
    step();
    bus.MEM_REQ = 1'b1; bus.MEM_WE = 1'b0; bus.MEM_SIZE = 2'b10; bus.MEM_ADDR = 8'h10; #1;
    chk("rb_en",    32'(bus.RAM_EN),    1);
    step(); step(); #1;
    chk("rb_vld",   32'(bus.MEM_VALID), 1);
    chk("rb_rd",    bus.MEM_RDATA,      32'h00CCBBAA);
    bus.MEM_REQ = 1'b0;

    // Flush during an in-flight fetch.
    step(); bus.IF_REQ = 1'b1; bus.IF_ADDR = 8'h0C; #1;
    chk("fl_gnt",   32'(bus.IF_GNT),    1);
    step(); bus.IF_FLUSH = 1'b1; bus.IF_ADDR = 8'h20; #1;
    chk("fl_stl",   32'(bus.IF_STALL),  0);
    step(); bus.IF_FLUSH = 1'b0; #1;
    chk("fl_novld", 32'(bus.IF_VALID),  0);
    chk("fl_rd",    bus.IF_RDATA,       32'hCAFEF00D);
    chk("fl_regnt", 32'(bus.IF_GNT),    1);
    chk("fl_addr",  32'(bus.RAM_ADDR),  32'h20);
    step(); step(); #1;
    chk("fl_vld",   32'(bus.IF_VALID),  1);
    chk("fl_rd2",   bus.IF_RDATA,       32'h12345678);
    bus.IF_REQ = 1'b0;

    // Reset in the middle of a MEM read.
    step(); bus.MEM_REQ = 1'b1; bus.MEM_ADDR = 8'h40; #1;
    chk("rm_en",    32'(bus.RAM_EN),    1);
    step(); rst = 1'b0; #1;
    chk("rm_stl",   32'(bus.MEM_STALL), 1);
    chk("rm_noen",  32'(bus.RAM_EN),    0);
    step(); rst = 1'b1; #1;
    chk("rm_novld", 32'(bus.MEM_VALID), 0);
    chk("rm_rd0",   bus.MEM_RDATA,      0);
    chk("rm_regnt", 32'(bus.RAM_EN),    1);
    chk("rm_addr",  32'(bus.RAM_ADDR),  32'h40);
    step(); #1;
    chk("rm_vld0",  32'(bus.MEM_VALID), 0);
    step(); #1;
    chk("rm_vld",   32'(bus.MEM_VALID), 1);
    chk("rm_rd",    bus.MEM_RDATA,      32'h11223344);
    bus.MEM_REQ = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
